// File: rtl/imm_packer_if.sv
// rtl/imm_packer_if.sv - producer/consumer handshake bundle for the immediate packer
interface imm_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [1:0]  in_imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  // Drives entries in and consumes packed instructions (testbench / surrounding logic)
  modport master (
    output in_valid, in_base, in_imm, in_imm_src, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  // The packer itself
  modport slave (
    input  in_valid, in_base, in_imm, in_imm_src, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - packs I/S/B immediates into instruction words with range checking; optional IMM_PACK_ERRCNT_EN adds err_count
module imm_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
`ifdef IMM_PACK_ERRCNT_EN
  output logic [7:0]   err_count,
`endif
  imm_packer_if.slave  bus
);

  logic [31:0] enc_instr;
  logic        enc_err;
  logic [31:0] out_instr_q;
  logic [31:0] out_addr_q;
  logic        out_err_q;
  logic        out_valid_q;
  logic [31:0] next_addr_q;
  logic [31:0] load_addr;
  logic        accept;
  logic        xfer;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = out_valid_q && bus.out_ready;

  // A restart in the same cycle as a load applies to that very entry
  assign load_addr = restart ? BASE_ADDR : next_addr_q;

  // Immediate field placement and range check; out-of-range values are still packed truncated
  always_comb begin
    enc_instr = bus.in_base;
    enc_err   = 1'b0;
    case (bus.in_imm_src)
      2'b00: begin
        enc_instr[31:20] = bus.in_imm[11:0];
        enc_err = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      end
      2'b01: begin
        enc_instr[31:25] = bus.in_imm[11:5];
        enc_instr[11:7]  = bus.in_imm[4:0];
        enc_err = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      end
      2'b10: begin
        enc_instr[31]    = bus.in_imm[12];
        enc_instr[7]     = bus.in_imm[11];
        enc_instr[30:25] = bus.in_imm[10:5];
        enc_instr[11:8]  = bus.in_imm[4:1];
        enc_err = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12])) || bus.in_imm[0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  // Single output register: load on accept (replacing a departing entry without a bubble), else drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_err_q   <= 1'b0;
      out_addr_q  <= BASE_ADDR;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_instr_q <= enc_instr;
      out_err_q   <= enc_err;
      out_addr_q  <= load_addr;
    end else if (xfer) begin
      out_valid_q <= 1'b0;
    end
  end

  // Address for the next loaded entry; every loaded entry leaves unless reset discards it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_addr_q <= BASE_ADDR;
    end else if (accept) begin
      next_addr_q <= load_addr + 32'd4;
    end else if (restart) begin
      next_addr_q <= BASE_ADDR;
    end
  end

`ifdef IMM_PACK_ERRCNT_EN
  // Saturating count of erroring entries handed to the consumer; restart clears it
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      err_count <= 8'd0;
    end else if (xfer && out_err_q && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_packer.sv
// tb/tb_imm_packer.sv - directed self-checking bench for imm_packer
module tb_imm_packer;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic clk;
  logic rst_n;
  logic restart;
  int   n_cmp;
  int   n_err;
`ifdef IMM_PACK_ERRCNT_EN
  logic [7:0] err_count;
`endif

  imm_packer_if bus ();

  imm_packer #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
`ifdef IMM_PACK_ERRCNT_EN
    .err_count (err_count),
`endif
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] src, input logic [31:0] base, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err, input logic [31:0] exp_addr);
    bus.in_valid   = 1'b1;
    bus.in_imm_src = src;
    bus.in_base    = base;
    bus.in_imm     = imm;
    tick();
    chk("send_valid", bus.out_valid, 1'b1);
    chk("send_instr", bus.out_instr, exp_instr);
    chk("send_err",   bus.out_err,   exp_err);
    chk("send_addr",  bus.out_addr,  exp_addr);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    restart = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_base = 32'h0;
    bus.in_imm = 32'h0;
    bus.in_imm_src = 2'b00;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_err",   bus.out_err,   1'b0);
    chk("rst_addr",  bus.out_addr,  BASE);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // encodings, range boundaries, illegal format, address wrap
    send(2'b00, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0, 32'hFFFF_FFF0);
    send(2'b01, 32'h0000_2023, 32'h0000_07FF, 32'h7E00_2FA3, 1'b0, 32'hFFFF_FFF4);
    send(2'b10, 32'h0000_0063, 32'hFFFF_F000, 32'h8000_0063, 1'b0, 32'hFFFF_FFF8);
    send(2'b10, 32'h0000_0063, 32'h0000_0003, 32'h0000_0163, 1'b1, 32'hFFFF_FFFC);
    send(2'b00, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1, 32'h0000_0000);
    send(2'b11, 32'h1234_5677, 32'hDEAD_BEEF, 32'h1234_5677, 1'b1, 32'h0000_0004);
    send(2'b00, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 1'b0, 32'h0000_0008);
    send(2'b10, 32'h0000_0063, 32'h0000_1000, 32'h8000_0063, 1'b1, 32'h0000_000C);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", bus.out_valid, 1'b0);

    // restart after several transfers, then backpressure
    restart = 1'b1;
    tick();
    restart = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_imm_src = 2'b00;
    bus.in_base = 32'h0000_0013;
    bus.in_imm = 32'h1;
    tick();
    chk("bp_first_addr", bus.out_addr, BASE);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    bus.in_imm = 32'h2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_instr", bus.out_instr, 32'h0010_0013);
      chk("bp_hold_addr",  bus.out_addr,  BASE);
      chk("bp_hold_ready", bus.in_ready,  1'b0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_rel_instr", bus.out_instr, 32'h0020_0013);
    chk("bp_rel_addr",  bus.out_addr,  BASE + 32'd4);
    bus.in_imm = 32'h3;
    tick();
    chk("bp_third_instr", bus.out_instr, 32'h0030_0013);
    chk("bp_third_addr",  bus.out_addr,  BASE + 32'd8);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drain", bus.out_valid, 1'b0);

    // restart while an entry is held leaves it intact
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_imm = 32'h4;
    tick();
    bus.in_valid = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rh_valid", bus.out_valid, 1'b1);
    chk("rh_instr", bus.out_instr, 32'h0040_0013);
    chk("rh_addr",  bus.out_addr,  BASE + 32'd12);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_imm = 32'h5;
    tick();
    chk("rh_next_instr", bus.out_instr, 32'h0050_0013);
    chk("rh_next_addr",  bus.out_addr,  BASE);

    // restart coinciding with an output transfer wins
    bus.in_valid = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rx_drained", bus.out_valid, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_imm = 32'h6;
    tick();
    chk("rx_addr", bus.out_addr, BASE);

    // reset discards a held entry
    bus.out_ready = 1'b0;
    bus.in_imm = 32'h7;
    tick();
    chk("rm_held", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rm_valid", bus.out_valid, 1'b0);
    chk("rm_addr",  bus.out_addr,  BASE);
    chk("rm_instr", bus.out_instr, 32'h0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rm_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    send(2'b00, 32'h0000_0013, 32'h0000_0008, 32'h0080_0013, 1'b0, BASE);
    bus.in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imm_packer.md
IMM_PACKER -- requirements
Module: imm_packer

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_0000, first word address emitted after reset or restart.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: restart  input  1  synchronous pulse, reloads address counter to BASE_ADDR.
REQ-005 Port: in_valid  input  1  producer presents an entry.
REQ-006 Port: in_ready  output  1  block accepts the entry this cycle.
REQ-007 Port: in_base  input  32  instruction with non-immediate fields populated; immediate field bits ignored.
REQ-008 Port: in_imm  input  32  immediate value, two's complement.
REQ-009 Port: in_imm_src  input  2  format: 00 I, 01 S, 10 B, 11 illegal.
REQ-010 Port: out_valid  output  1  registered entry available.
REQ-011 Port: out_ready  input  1  consumer accepts the entry this cycle.
REQ-012 Port: out_instr  output  32  encoded instruction.
REQ-013 Port: out_addr  output  32  instruction-memory word address for out_instr.
REQ-014 Port: out_err  output  1  immediate out of range, misaligned, or illegal format.

Function
REQ-015 The block SHALL accept an entry when in_valid && in_ready, and transfer out when out_valid && out_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready (single-register pipeline, one entry per cycle sustained).
REQ-017 Latency SHALL be one cycle: an entry accepted in cycle N is presented at out_* in cycle N+1.
REQ-018 out_instr, out_err, out_addr SHALL be held stable while out_valid && !out_ready.
REQ-019 I: out_instr[31:20]=imm[11:0]; other bits from in_base.
REQ-020 S: out_instr[31:25]=imm[11:5], [11:7]=imm[4:0]; other bits from in_base.
REQ-021 B: out_instr[31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; other bits from in_base.
REQ-022 Illegal format: out_instr = in_base unchanged, out_err=1.
REQ-023 I/S range: err when imm[31:11] not all equal.
REQ-024 B range: err when imm[31:12] not all equal, or imm[0]=1.
REQ-025 An erroring entry SHALL still be emitted, with the truncated field bits packed as in REQ-019..021.
REQ-026 out_addr SHALL equal BASE_ADDR for the first entry, then increment by 4 after each output transfer, wrapping modulo 2^32.
REQ-027 restart SHALL set the address for the next loaded entry to BASE_ADDR, without altering a held output entry or its out_addr; a simultaneous restart and output transfer SHALL result in restart winning.
REQ-028 Simultaneous output transfer and input acceptance SHALL replace the register with the new entry without a bubble.

Reset
REQ-029 While rst_n=0 at a clock edge: out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, next address=BASE_ADDR.
REQ-030 Reset SHALL discard any held entry mid-handshake; in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro IMM_PACK_ERRCNT_EN defined: add output port err_count (8 bits), a saturating count of output transfers with out_err=1, reset to 0, cleared by restart.
REQ-032 Macro IMM_PACK_ERRCNT_EN undefined: port err_count and its logic SHALL be absent, all other behaviour identical.

Verification
REQ-033 I, base=32'h0000_0013, imm=32'hFFFF_FFFF, out_ready=1 -> next cycle out_instr=32'hFFF0_0013, err=0, addr=0.
REQ-034 S, base=32'h0000_2023, imm=32'h0000_07FF -> out_instr=32'h7E00_2FA3, err=0.
REQ-035 B, base=32'h0000_0063, imm=32'hFFFF_F000 -> out_instr=32'h8000_0063; imm=32'h0000_0003 -> err=1.
REQ-036 I, imm=32'h0000_0800 -> err=1, out_instr[31:20]=12'h800; src=11 -> out_instr=base, err=1.
REQ-037 Backpressure: out_ready=0 for 3 cycles with in_valid held -> output stable, in_ready=0; release -> addresses 0,4,8 in order, no loss or duplication.
REQ-038 Reset asserted with out_valid=1 -> out_valid=0, addr=BASE_ADDR; restart pulse after 5 transfers -> next accepted entry addr=BASE_ADDR.
